cnt_cmd_sequencer: RTL and testbench

Upstream stimulus/control stage for the 8-bit up/down counter. Accepts queued commands over a valid/ready interface: LOAD value, count UP n cycles, count DOWN n cycles, HOLD n cycles. Translates each command into the counter's control pins: ld_cnt_ (active-low), count_enb, updn_cnt, data_in. Keeps a shadow model of the counter value (exp_count) so the downstream property checker and scoreboard can compare against data_out.

---
 rtl/cnt_cmd_sequencer_if.sv | 27 ++
 rtl/cnt_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_cnt_cmd_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_cmd_sequencer_if.sv
// Command handshake between the stimulus source and cnt_cmd_sequencer.
//   cmd_valid  command present on cmd_op/cmd_arg
//   cmd_ready  sequencer can accept (command FIFO not full)
//   cmd_op     00 HOLD, 01 LOAD, 10 UP, 11 DOWN
//   cmd_arg    LOAD: load value; others: cycle count
interface cnt_cmd_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/cnt_cmd_sequencer.sv
// Command sequencer for the 8-bit up/down counter. Queues LOAD/UP/DOWN/HOLD
// commands in a small FIFO and drives the counter control pins, while
// keeping a shadow copy of the counter value for downstream checking.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous active-high reset
//   cmd        command handshake (slave side)
//   ld_cnt_    counter load strobe, active-low
//   count_enb  counter enable
//   updn_cnt   1 = count up, 0 = count down
//   data_in    counter load data
//   exp_count  predicted counter value after each posedge
//   busy       a command is executing
//   done       final execution cycle of the current command
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | no command executing, waiting for FIFO non-empty
// ST_LOAD | single-cycle load strobe
// ST_RUN  | UP/DOWN/HOLD for n cycles (n = 0 is a one-cycle no-op)
module cnt_cmd_sequencer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    cnt_cmd_sequencer_if.slave cmd,
    output logic              ld_cnt_,
    output logic              count_enb,
    output logic              updn_cnt,
    output logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] exp_count,
    output logic              busy,
    output logic              done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t            state;
    logic [DATA_W-1:0] rem;

    logic [1:0]        fifo_op  [DEPTH];
    logic [DATA_W-1:0] fifo_arg [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [1:0]        head_op;
    logic [DATA_W-1:0] head_arg;

    // Ready depends only on occupancy: a pop in the same cycle does not
    // open a slot for a push while full.
    assign full          = (occ == OCC_FULL);
    assign empty         = (occ == '0);
    assign cmd.cmd_ready = !full;
    assign push          = cmd.cmd_valid && !full;
    // done only ever asserts outside IDLE, so it marks the final cycle of
    // the running command; popping there gives zero-bubble chaining.
    assign pop           = !empty && ((state == ST_IDLE) || done);
    assign head_op       = fifo_op[rd_ptr];
    assign head_arg      = fifo_arg[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]  <= cmd.cmd_op;
            fifo_arg[wr_ptr] <= cmd.cmd_arg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rem       <= '0;
            ld_cnt_   <= 1'b1;
            count_enb <= 1'b0;
            updn_cnt  <= 1'b1;
            data_in   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (pop) begin
            busy <= 1'b1;
            if (head_op == OP_LOAD) begin
                state     <= ST_LOAD;
                ld_cnt_   <= 1'b0;
                data_in   <= head_arg;
                count_enb <= 1'b0;
                done      <= 1'b1;
            end else begin
                state   <= ST_RUN;
                ld_cnt_ <= 1'b1;
                rem     <= head_arg - 1'b1;
                if (head_arg == '0) begin
                    count_enb <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    count_enb <= (head_op != OP_HOLD);
                    if (head_op == OP_UP)   updn_cnt <= 1'b1;
                    if (head_op == OP_DOWN) updn_cnt <= 1'b0;
                    done <= (head_arg == DATA_W'(1));
                end
            end
        end else if ((state != ST_IDLE) && done) begin
            // updn_cnt and data_in deliberately keep their last values
            state     <= ST_IDLE;
            busy      <= 1'b0;
            ld_cnt_   <= 1'b1;
            count_enb <= 1'b0;
            done      <= 1'b0;
        end else if (state == ST_RUN) begin
            rem  <= rem - 1'b1;
            done <= (rem == DATA_W'(1));
        end
    end

    // Mirrors the counter: samples the same registered pins at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_count <= '0;
        end else if (!ld_cnt_) begin
            exp_count <= data_in;
        end else if (count_enb && updn_cnt) begin
            exp_count <= exp_count + 1'b1;
        end else if (count_enb) begin
            exp_count <= exp_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_cnt_cmd_sequencer.sv
module tb_cnt_cmd_sequencer;
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_cnt_, count_enb, updn_cnt, busy, done;
    logic [7:0] data_in, exp_count;

    cnt_cmd_sequencer_if #(.DATA_W(8)) cmd_if ();

    cnt_cmd_sequencer #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .ld_cnt_   (ld_cnt_),
        .count_enb (count_enb),
        .updn_cnt  (updn_cnt),
        .data_in   (data_in),
        .exp_count (exp_count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [7:0] arg;
        logic       ld, en, ud;
        logic [7:0] di, ec;
        logic       bsy, dn, rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [1:0] op, input logic [7:0] arg,
                                input logic ld, input logic en, input logic ud,
                                input logic [7:0] di, input logic [7:0] ec,
                                input logic bsy, input logic dn, input logic rdy);
        vecs.push_back('{v, op, arg, ld, en, ud, di, ec, bsy, dn, rdy});
    endfunction

    // Monitor for the backpressure test
    logic       mon_en = 1'b0;
    int         mon_done = 0;
    int         mon_busy = 0;
    logic [7:0] ld_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (done)     mon_done++;
            if (busy)     mon_busy++;
            if (!ld_cnt_) ld_q.push_back(data_in);
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] arg);
        int waited = 0;
        logic timed_out = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        while (!cmd_if.cmd_ready && !timed_out) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 40) timed_out = 1'b1;
        end
        if (!timed_out) begin
            @(posedge clk); #1;
        end
        cmd_if.cmd_valid = 1'b0;
        chk("push_timeout", {31'd0, timed_out}, 32'd0);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        logic timed_out = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n > max_cycles) timed_out = 1'b1;
        end while (busy && !timed_out);
        chk("idle_timeout", {31'd0, timed_out}, 32'd0);
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_HOLD;
        cmd_if.cmd_arg   = 8'h00;

        // ld  en  ud  di     ec     bsy dn rdy
        add(1, OP_LOAD, 8'hA5, 1, 0, 1, 8'h00, 8'h00, 0, 0, 1);
        add(1, OP_UP,   8'h03, 0, 0, 1, 8'hA5, 8'h00, 1, 1, 1);
        add(0, OP_HOLD, 8'h00, 1, 1, 1, 8'hA5, 8'hA5, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 1, 1, 8'hA5, 8'hA6, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 1, 1, 8'hA5, 8'hA7, 1, 1, 1);
        add(0, OP_HOLD, 8'h00, 1, 0, 1, 8'hA5, 8'hA8, 0, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 0, 1, 8'hA5, 8'hA8, 0, 0, 1);
        add(1, OP_LOAD, 8'hFE, 1, 0, 1, 8'hA5, 8'hA8, 0, 0, 1);
        add(1, OP_UP,   8'h03, 0, 0, 1, 8'hFE, 8'hA8, 1, 1, 1);
        add(1, OP_DOWN, 8'h04, 1, 1, 1, 8'hFE, 8'hFE, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 1, 1, 8'hFE, 8'hFF, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 1, 1, 8'hFE, 8'h00, 1, 1, 1);
        add(0, OP_HOLD, 8'h00, 1, 1, 0, 8'hFE, 8'h01, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 1, 0, 8'hFE, 8'h00, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 1, 0, 8'hFE, 8'hFF, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 1, 0, 8'hFE, 8'hFE, 1, 1, 1);
        add(0, OP_HOLD, 8'h00, 1, 0, 0, 8'hFE, 8'hFD, 0, 0, 1);
        add(1, OP_HOLD, 8'h05, 1, 0, 0, 8'hFE, 8'hFD, 0, 0, 1);
        add(1, OP_UP,   8'h00, 1, 0, 0, 8'hFE, 8'hFD, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 0, 0, 8'hFE, 8'hFD, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 0, 0, 8'hFE, 8'hFD, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 0, 0, 8'hFE, 8'hFD, 1, 0, 1);
        add(0, OP_HOLD, 8'h00, 1, 0, 0, 8'hFE, 8'hFD, 1, 1, 1);
        add(0, OP_HOLD, 8'h00, 1, 0, 0, 8'hFE, 8'hFD, 1, 1, 1);
        add(0, OP_HOLD, 8'h00, 1, 0, 0, 8'hFE, 8'hFD, 0, 0, 1);

        // Reset held for 3 cycles, then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ld",   {31'd0, ld_cnt_},   32'd1);
        chk("rst_en",   {31'd0, count_enb}, 32'd0);
        chk("rst_ud",   {31'd0, updn_cnt},  32'd1);
        chk("rst_di",   {24'd0, data_in},   32'd0);
        chk("rst_ec",   {24'd0, exp_count}, 32'd0);
        chk("rst_busy", {31'd0, busy},      32'd0);
        chk("rst_done", {31'd0, done},      32'd0);
        chk("rst_rdy",  {31'd0, cmd_if.cmd_ready}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_ld",   {31'd0, ld_cnt_},   32'd1);
            chk("idle_en",   {31'd0, count_enb}, 32'd0);
            chk("idle_ec",   {24'd0, exp_count}, 32'd0);
            chk("idle_busy", {31'd0, busy},      32'd0);
            chk("idle_rdy",  {31'd0, cmd_if.cmd_ready}, 32'd1);
        end

        // Directed per-cycle vectors: load/up, wrap, hold and zero-arg
        for (int i = 0; i < vecs.size(); i++) begin
            cmd_if.cmd_valid = vecs[i].v;
            cmd_if.cmd_op    = vecs[i].op;
            cmd_if.cmd_arg   = vecs[i].arg;
            @(posedge clk); #1;
            if (ld_cnt_ !== vecs[i].ld || count_enb !== vecs[i].en || updn_cnt !== vecs[i].ud ||
                data_in !== vecs[i].di || exp_count !== vecs[i].ec || busy !== vecs[i].bsy ||
                done !== vecs[i].dn || cmd_if.cmd_ready !== vecs[i].rdy)
                $display("vector %0d: ld=%b en=%b ud=%b di=%h ec=%h busy=%b done=%b rdy=%b",
                         i, ld_cnt_, count_enb, updn_cnt, data_in, exp_count, busy, done,
                         cmd_if.cmd_ready);
            chk("vec_ld",   {31'd0, ld_cnt_},   {31'd0, vecs[i].ld});
            chk("vec_en",   {31'd0, count_enb}, {31'd0, vecs[i].en});
            chk("vec_ud",   {31'd0, updn_cnt},  {31'd0, vecs[i].ud});
            chk("vec_di",   {24'd0, data_in},   {24'd0, vecs[i].di});
            chk("vec_ec",   {24'd0, exp_count}, {24'd0, vecs[i].ec});
            chk("vec_busy", {31'd0, busy},      {31'd0, vecs[i].bsy});
            chk("vec_done", {31'd0, done},      {31'd0, vecs[i].dn});
            chk("vec_rdy",  {31'd0, cmd_if.cmd_ready}, {31'd0, vecs[i].rdy});
        end
        cmd_if.cmd_valid = 1'b0;

        // FIFO full / backpressure during a long UP 20
        mon_en = 1'b1;
        push_cmd(OP_UP,   8'd20);
        push_cmd(OP_LOAD, 8'h11);
        push_cmd(OP_UP,   8'd1);
        push_cmd(OP_DOWN, 8'd1);
        push_cmd(OP_HOLD, 8'd1);
        chk("full_rdy", {31'd0, cmd_if.cmd_ready}, 32'd0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_LOAD;
        cmd_if.cmd_arg   = 8'h22;
        @(posedge clk); #1;
        chk("fifth_held", {31'd0, cmd_if.cmd_ready}, 32'd0);
        push_cmd(OP_LOAD, 8'h22);
        wait_idle(100);
        mon_en = 1'b0;
        chk("bp_done_cnt", mon_done, 32'd6);
        chk("bp_busy_cnt", mon_busy, 32'd25);
        chk("bp_ld_cnt",   ld_q.size(), 32'd2);
        if (ld_q.size() == 2) begin
            chk("bp_ld0", {24'd0, ld_q[0]}, 32'h11);
            chk("bp_ld1", {24'd0, ld_q[1]}, 32'h22);
        end
        chk("bp_ec",  {24'd0, exp_count}, 32'h22);
        chk("bp_rdy", {31'd0, cmd_if.cmd_ready}, 32'd1);

        // Reset in cycle 2 of UP 10 with two commands queued
        push_cmd(OP_UP,   8'd10);
        push_cmd(OP_LOAD, 8'h33);
        push_cmd(OP_UP,   8'd2);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ld",   {31'd0, ld_cnt_},   32'd1);
        chk("arst_en",   {31'd0, count_enb}, 32'd0);
        chk("arst_ud",   {31'd0, updn_cnt},  32'd1);
        chk("arst_di",   {24'd0, data_in},   32'd0);
        chk("arst_ec",   {24'd0, exp_count}, 32'd0);
        chk("arst_busy", {31'd0, busy},      32'd0);
        chk("arst_done", {31'd0, done},      32'd0);
        chk("arst_rdy",  {31'd0, cmd_if.cmd_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        push_cmd(OP_LOAD, 8'h10);
        @(posedge clk); #1;
        chk("reload_ld",   {31'd0, ld_cnt_}, 32'd0);
        chk("reload_di",   {24'd0, data_in}, 32'h10);
        chk("reload_done", {31'd0, done},    32'd1);
        @(posedge clk); #1;
        chk("reload_ec",   {24'd0, exp_count}, 32'h10);
        chk("reload_idle", {31'd0, busy},      32'd0);
        chk("reload_ld1",  {31'd0, ld_cnt_},   32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
